// File: rtl/aidan_mcnay_prime_pkg.sv
// Shared definitions for the prime-detector front end.
//   NIBBLE_W : width of one keyed-in nibble
//   DATA_W   : default candidate width (four nibbles)
//   state_t  : controller state encoding
package aidan_mcnay_prime_pkg;

    localparam int NIBBLE_W = 4;
    localparam int DATA_W   = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/aidan_mcnay_change_detect.sv
// Single-signal change detector: out_signal is high for the cycle in which
// in_signal differs from its value at the previous clock edge.
//   clk        : system clock
//   in_signal  : level to watch
//   out_signal : combinational "changed since last edge" flag
// The history register has no reset; users mask the first cycle themselves.
module aidan_mcnay_change_detect (
    input  logic clk,
    input  logic in_signal,
    output logic out_signal
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        prev_reg <= in_signal;
    end

    assign out_signal = in_signal ^ prev_reg;

endmodule

// File: rtl/aidan_mcnay_prime_input_ctrl.sv
// Front-end controller for the prime detector.
// Builds a candidate from NIBBLES nibble entries (first entry lands in the
// most significant nibble), sends it over a val/rdy request, collects the
// one-bit verdict and holds it for display until the next entry starts.
//   clk, rst                     : clock, asynchronous active-high reset
//   load_btn, clr_btn            : synchronized raw button levels
//   nibble_in                    : nibble captured on a load press
//   req_val/req_rdy/req_msg      : candidate toward the detector
//   resp_val/resp_rdy/resp_prime : verdict from the detector
//   result_val, result_prime     : held verdict for display
//   nibble_cnt                   : nibbles entered in the current candidate
//   busy                         : high while sending or awaiting a verdict
module aidan_mcnay_prime_input_ctrl
    import aidan_mcnay_prime_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_btn,
    input  logic                          clr_btn,
    input  logic [NIBBLE_W-1:0]           nibble_in,
    output logic                          req_val,
    input  logic                          req_rdy,
    output logic [NIBBLE_W*NIBBLES-1:0]   req_msg,
    input  logic                          resp_val,
    output logic                          resp_rdy,
    input  logic                          resp_prime,
    output logic                          result_val,
    output logic                          result_prime,
    output logic [1:0]                    nibble_cnt,
    output logic                          busy
);

    localparam int MSG_W = NIBBLE_W * NIBBLES;
    localparam logic [1:0] LAST_CNT = 2'(NIBBLES - 1);

    // Button edge detection: index 0 = load, index 1 = clear.
    logic [1:0] btn_lvl;
    logic [1:0] btn_chg;
    logic [1:0] btn_pulse;
    logic       arm_reg;

    assign btn_lvl = {clr_btn, load_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            aidan_mcnay_change_detect u_cd (
                .clk        (clk),
                .in_signal  (btn_lvl[gi]),
                .out_signal (btn_chg[gi])
            );
            // Rising edges only; masked until the history register has
            // seen one post-reset clock.
            assign btn_pulse[gi] = btn_chg[gi] & btn_lvl[gi] & arm_reg;
        end
    endgenerate

    logic load_pulse;
    logic clr_pulse;
    assign load_pulse = btn_pulse[0];
    assign clr_pulse  = btn_pulse[1];

    state_t           state_reg, state_next;
    logic [MSG_W-1:0] data_reg, data_next;
    logic [1:0]       cnt_reg, cnt_next;
    logic             result_val_reg, result_val_next;
    logic             result_prime_reg, result_prime_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_COLLECT;
            data_reg         <= '0;
            cnt_reg          <= '0;
            arm_reg          <= 1'b0;
            result_val_reg   <= 1'b0;
            result_prime_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            data_reg         <= data_next;
            cnt_reg          <= cnt_next;
            arm_reg          <= 1'b1;
            result_val_reg   <= result_val_next;
            result_prime_reg <= result_prime_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        data_next         = data_reg;
        cnt_next          = cnt_reg;
        result_val_next   = result_val_reg;
        result_prime_next = result_prime_reg;

        unique case (state_reg)
            ST_COLLECT: begin
                // Clear has priority; a simultaneous nibble is dropped.
                if (clr_pulse) begin
                    data_next = '0;
                    cnt_next  = '0;
                end else if (load_pulse) begin
                    data_next = {data_reg[MSG_W-NIBBLE_W-1:0], nibble_in};
                    if (cnt_reg == LAST_CNT) begin
                        cnt_next   = '0;
                        state_next = ST_SEND;
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end
            end
            ST_SEND: begin
                if (req_rdy) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resp_val) begin
                    result_prime_next = resp_prime;
                    result_val_next   = 1'b1;
                    state_next        = ST_DONE;
                end
            end
            ST_DONE: begin
                // A load here is the first nibble of a new candidate.
                if (clr_pulse) begin
                    result_val_next = 1'b0;
                    data_next       = '0;
                    cnt_next        = '0;
                    state_next      = ST_COLLECT;
                end else if (load_pulse) begin
                    result_val_next = 1'b0;
                    data_next       = {{(MSG_W-NIBBLE_W){1'b0}}, nibble_in};
                    cnt_next        = 2'd1;
                    state_next      = ST_COLLECT;
                end
            end
            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    // Moore outputs: decoded from state alone.
    assign req_val      = (state_reg == ST_SEND);
    assign resp_rdy     = (state_reg == ST_WAIT);
    assign busy         = (state_reg == ST_SEND) | (state_reg == ST_WAIT);
    assign req_msg      = data_reg;
    assign nibble_cnt   = cnt_reg;
    assign result_val   = result_val_reg;
    assign result_prime = result_prime_reg;

endmodule

// File: tb/tb_aidan_mcnay_prime_input_ctrl.sv
module tb_aidan_mcnay_prime_input_ctrl;

    localparam int NIBBLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_btn = 1'b0;
    logic        clr_btn = 1'b0;
    logic [3:0]  nibble_in = 4'h0;
    logic        req_val;
    logic        req_rdy = 1'b0;
    logic [15:0] req_msg;
    logic        resp_val = 1'b0;
    logic        resp_rdy;
    logic        resp_prime = 1'b0;
    logic        result_val;
    logic        result_prime;
    logic [1:0]  nibble_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aidan_mcnay_prime_input_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_btn     (load_btn),
        .clr_btn      (clr_btn),
        .nibble_in    (nibble_in),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_prime   (resp_prime),
        .result_val   (result_val),
        .result_prime (result_prime),
        .nibble_cnt   (nibble_cnt),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the candidate as a running value plus entry count, and the
    // transaction phase as independent flags: candidate pending, verdict
    // awaited, verdict shown.
    logic        m_prev_load = 1'b0, m_prev_clr = 1'b0;
    logic        m_armed, m_have, m_wait, m_shown, m_prime;
    int          m_ent_cnt;
    logic [15:0] m_ent_val, m_cand;
    logic        m_lp, m_cp;

    always @(posedge clk) begin
        m_prev_load <= load_btn;
        m_prev_clr  <= clr_btn;
    end

    assign m_lp = m_armed & load_btn & ~m_prev_load;
    assign m_cp = m_armed & clr_btn & ~m_prev_clr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_armed <= 1'b0; m_have <= 1'b0; m_wait <= 1'b0;
            m_shown <= 1'b0; m_prime <= 1'b0;
            m_ent_cnt <= 0; m_ent_val <= '0; m_cand <= '0;
        end else begin
            m_armed <= 1'b1;
            if (m_have) begin
                if (req_rdy) begin
                    m_have <= 1'b0;
                    m_wait <= 1'b1;
                end
            end else if (m_wait) begin
                if (resp_val) begin
                    m_wait  <= 1'b0;
                    m_shown <= 1'b1;
                    m_prime <= resp_prime;
                end
            end else if (m_cp) begin
                m_shown   <= 1'b0;
                m_ent_cnt <= 0;
                m_ent_val <= '0;
            end else if (m_lp) begin
                m_shown <= 1'b0;
                if (m_ent_cnt + 1 == NIBBLES) begin
                    m_cand    <= (m_ent_val << 4) | 16'(nibble_in);
                    m_have    <= 1'b1;
                    m_ent_cnt <= 0;
                    m_ent_val <= '0;
                end else begin
                    m_ent_cnt <= m_ent_cnt + 1;
                    m_ent_val <= (m_ent_val << 4) | 16'(nibble_in);
                end
            end
        end
    end

    logic done_flag = 1'b0;

    always @(negedge clk) begin
        if (!done_flag) begin
            check("cyc_req_val", 32'(req_val), 32'(m_have));
            check("cyc_resp_rdy", 32'(resp_rdy), 32'(m_wait));
            check("cyc_busy", 32'(busy), 32'(m_have | m_wait));
            check("cyc_nibble_cnt", 32'(nibble_cnt), 32'(m_ent_cnt));
            check("cyc_req_msg", 32'(req_msg),
                  32'((m_have | m_wait | m_shown) ? m_cand : m_ent_val));
            check("cyc_result_val", 32'(result_val), 32'(m_shown));
            check("cyc_result_prime", 32'(result_prime), 32'(m_prime));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] nib);
        load_btn  = 1'b1;
        nibble_in = nib;
        tick();
        load_btn = 1'b0;
        tick();
    endtask

    task automatic press_clr();
        clr_btn = 1'b1;
        tick();
        clr_btn = 1'b0;
        tick();
    endtask

    task automatic wait_result(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_val) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) tick();
        check("rst_req_val", 32'(req_val), 32'd0);
        check("rst_req_msg", 32'(req_msg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        $display("txn reset done");

        // Entry and verdict: F F F 1
        req_rdy = 1'b1;
        press(4'hF); press(4'hF); press(4'hF);
        load_btn = 1'b1; nibble_in = 4'h1;
        tick();
        check("t1_req_val", 32'(req_val), 32'd1);
        check("t1_req_msg", 32'(req_msg), 32'hFFF1);
        check("t1_busy", 32'(busy), 32'd1);
        load_btn = 1'b0;
        tick();
        check("t1_resp_rdy", 32'(resp_rdy), 32'd1);
        check("t1_req_val_drop", 32'(req_val), 32'd0);
        resp_val = 1'b1; resp_prime = 1'b1;
        wait_result("t1_wait_result");
        resp_val = 1'b0;
        check("t1_result_prime", 32'(result_prime), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd0);
        $display("txn entry candidate=%04h prime=%0d", req_msg, result_prime);

        // Backpressure: 0007 with req_rdy low
        req_rdy = 1'b0;
        press(4'h0);
        check("t2_restart_result_val", 32'(result_val), 32'd0);
        press(4'h0); press(4'h0);
        load_btn = 1'b1; nibble_in = 4'h7;
        tick();
        load_btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_req_val", 32'(req_val), 32'd1);
            check("t2_hold_req_msg", 32'(req_msg), 32'h0007);
            tick();
        end
        press(4'h9);
        check("t2_send_ignore_cnt", 32'(nibble_cnt), 32'd0);
        check("t2_send_ignore_msg", 32'(req_msg), 32'h0007);
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        check("t2_wait_resp_rdy", 32'(resp_rdy), 32'd1);
        press(4'h9);
        check("t2_wait_ignore_cnt", 32'(nibble_cnt), 32'd0);
        check("t2_wait_ignore_msg", 32'(req_msg), 32'h0007);
        resp_val = 1'b1; resp_prime = 1'b0;
        tick();
        resp_val = 1'b0;
        check("t2_result_val", 32'(result_val), 32'd1);
        check("t2_result_prime", 32'(result_prime), 32'd0);
        $display("txn backpressure candidate=%04h prime=%0d", req_msg, result_prime);

        // Clear
        press(4'hA);
        check("t3_cnt1", 32'(nibble_cnt), 32'd1);
        press(4'hB);
        check("t3_cnt2", 32'(nibble_cnt), 32'd2);
        check("t3_msg_ab", 32'(req_msg), 32'h00AB);
        press_clr();
        check("t3_cnt0", 32'(nibble_cnt), 32'd0);
        check("t3_msg_clr", 32'(req_msg), 32'h0000);
        press(4'h0); press(4'h0); press(4'h0);
        load_btn = 1'b1; nibble_in = 4'h2;
        tick();
        load_btn = 1'b0;
        check("t3_req_msg", 32'(req_msg), 32'h0002);
        check("t3_req_val", 32'(req_val), 32'd1);
        tick();
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        resp_val = 1'b1; resp_prime = 1'b1;
        tick();
        resp_val = 1'b0;
        check("t3_result_prime", 32'(result_prime), 32'd1);
        $display("txn clear candidate=%04h prime=%0d", req_msg, result_prime);

        // Restart from DONE, then simultaneous pulses
        press(4'h3);
        check("t4_result_val", 32'(result_val), 32'd0);
        check("t4_cnt", 32'(nibble_cnt), 32'd1);
        check("t4_msg", 32'(req_msg), 32'h0003);
        load_btn = 1'b1; clr_btn = 1'b1; nibble_in = 4'h5;
        tick();
        check("t4_both_cnt", 32'(nibble_cnt), 32'd0);
        check("t4_both_msg", 32'(req_msg), 32'h0000);
        load_btn = 1'b0; clr_btn = 1'b0;
        tick();
        $display("txn restart/simultaneous cnt=%0d", nibble_cnt);

        // Held button: exactly one count
        load_btn = 1'b1; nibble_in = 4'h6;
        repeat (10) tick();
        check("t5_held_cnt", 32'(nibble_cnt), 32'd1);
        check("t5_held_msg", 32'(req_msg), 32'h0006);
        load_btn = 1'b0;
        tick();
        check("t5_release_cnt", 32'(nibble_cnt), 32'd1);
        $display("txn held button cnt=%0d", nibble_cnt);

        // Reset mid-operation (in WAIT)
        press(4'h0); press(4'h0);
        load_btn = 1'b1; nibble_in = 4'h8;
        tick();
        load_btn = 1'b0;
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        check("t6_in_wait", 32'(resp_rdy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_req_val", 32'(req_val), 32'd0);
        check("t6_rst_resp_rdy", 32'(resp_rdy), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_cnt", 32'(nibble_cnt), 32'd0);
        check("t6_rst_msg", 32'(req_msg), 32'd0);
        check("t6_rst_result_val", 32'(result_val), 32'd0);
        check("t6_rst_result_prime", 32'(result_prime), 32'd0);
        tick(); tick();
        rst = 1'b0;
        load_btn = 1'b1; nibble_in = 4'h4;
        tick();
        check("t6_first_cycle_masked", 32'(nibble_cnt), 32'd0);
        load_btn = 1'b0;
        tick();
        press(4'h5);
        check("t6_after_arm_cnt", 32'(nibble_cnt), 32'd1);
        check("t6_after_arm_msg", 32'(req_msg), 32'h0005);
        $display("txn reset mid-op cnt=%0d", nibble_cnt);

        tick();
        done_flag = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
